// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int OPCODE_WIDTH = 6;

endpackage

// File: rtl/branch_target.sv
// Next-PC arithmetic: sequential increment or PC-relative branch, modulo 2^PC_WIDTH.
module branch_target #(
    parameter int PC_WIDTH     = 8,
    parameter int OFFSET_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic                    pc_rel_branch,
    output logic [PC_WIDTH-1:0]     next_pc,
    output logic                    self_jump
);

    logic signed [PC_WIDTH-1:0] offset_ext;

    // Sign-extend, then add unsigned so the sum wraps naturally at the PC width.
    assign offset_ext = PC_WIDTH'(signed'(offset));
    assign next_pc    = pc_rel_branch ? pc + PC_WIDTH'(offset_ext) : pc + PC_WIDTH'(1);
    assign self_jump  = pc_rel_branch && (offset == '0);

endmodule

// File: rtl/opcodes.sv
// Opcode definitions for the processor's instruction set, shared by fetch and decode.
`ifndef OPCODES_SV
`define OPCODES_SV
`define NOP 6'h00
`define ADD 6'h01
`define BEQ 6'h10
`define JMP 6'h11
`endif

// File: rtl/instr_fetch.sv
// Program counter, run/stall/halt control and retired-instruction counter feeding the decoder.
`include "opcodes.sv"

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH     = 8,
    parameter int INSTR_WIDTH  = 24,
    parameter int OFFSET_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   stall,
    input  logic                   pc_rel_branch,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [5:0]             opcode,
    output logic                   instr_valid,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [PC_WIDTH-1:0]   next_pc;
    logic                  self_jump;
    logic                  retire;
    logic                  unused_instr;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    branch_target #(
        .PC_WIDTH     (PC_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_branch_target (
        .pc            (pc),
        .offset        (instr[OFFSET_WIDTH-1:0]),
        .pc_rel_branch (pc_rel_branch),
        .next_pc       (next_pc),
        .self_jump     (self_jump)
    );

    // Bits between opcode and offset belong to the decoder, not to fetch.
    assign unused_instr = ^instr;

    // A stall in RUN wins over any branch: nothing retires and pc holds.
    assign retire = (state == RUN) && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = run ? RUN : IDLE;
            RUN:     state_next = stall ? STALL : (self_jump ? HALT : RUN);
            STALL:   state_next = stall ? STALL : RUN;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_valid = (state == RUN);
        halted      = (state == HALT);
        opcode      = `NOP;
        if (state == RUN) begin
            opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            retired <= '0;
        end else begin
            if (state == IDLE) begin
                pc <= '0;
            end else if (retire) begin
                pc <= next_pc;
            end
            if (retire) begin
                retired <= sat_inc(retired);
            end
        end
    end

endmodule
